// File: rtl/lu_pkg.sv
// Shared types for the pipelined logic unit: operation encoding and depth limit.
package lu_pkg;

    typedef enum logic [1:0] {
        LU_AND = 2'b00,
        LU_OR  = 2'b01,
        LU_XOR = 2'b10,
        LU_NOR = 2'b11
    } lu_op_t;

    localparam int LU_MAX_STAGES = 4;

endpackage

// File: rtl/lu_slice.sv
// One valid/ready register slice: a valid bit plus a payload register that
// loads only when the slice advances and upstream offers a beat.
module lu_slice #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    input  logic         down_ready,
    output logic         advance,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_r;
    logic [W-1:0] data_r;

    // An empty slice always accepts, so bubbles collapse.
    assign advance = !valid_r || down_ready;
    assign valid   = valid_r;
    assign data    = data_r;

    // Occupancy: take upstream valid on advance, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
        end else if (advance) begin
            valid_r <= up_valid;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Payload: load a real beat on advance, keep last value otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= RST_VAL;
        end else if (advance && up_valid) begin
            data_r <= up_data;
        end else begin
            data_r <= data_r;
        end
    end

endmodule

// File: rtl/logic32_pipe.sv
// Pipelined AND/OR/XOR/NOR unit with valid/ready flow control over STAGES slices.
// Optional zero/ones result flags are enabled by defining LU_FLAGS_EN.
module logic32_pipe
    import lu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  lu_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f
`ifdef LU_FLAGS_EN
    ,
    output logic             zero,
    output logic             ones
`endif
);

    localparam int NS = (STAGES < 1) ? 1 :
                        (STAGES > LU_MAX_STAGES) ? LU_MAX_STAGES : STAGES;

`ifdef LU_FLAGS_EN
    // Flags ride in the two top payload bits: {zero, ones, result}.
    localparam int              PW          = WIDTH + 2;
    localparam logic [PW-1:0]   PAYLOAD_RST = {1'b1, 1'b0, {WIDTH{1'b0}}};
`else
    localparam int              PW          = WIDTH;
    localparam logic [PW-1:0]   PAYLOAD_RST = {PW{1'b0}};
`endif

    logic [WIDTH-1:0] res_s;
    logic [PW-1:0]    payload_s;

    // Operation result, purely from the current operands.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        case (op)
            LU_AND:  res_s = a & b;
            LU_OR:   res_s = a | b;
            LU_XOR:  res_s = a ^ b;
            LU_NOR:  res_s = ~(a | b);
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

`ifdef LU_FLAGS_EN
    assign payload_s = {(res_s == {WIDTH{1'b0}}), (&res_s), res_s};
`else
    assign payload_s = res_s;
`endif

    for (genvar i = 0; i < NS; i++) begin : g_slice
        logic          up_valid_s;
        logic [PW-1:0] up_data_s;
        logic          down_ready_s;
        logic          adv_s;
        logic          valid_s;
        logic [PW-1:0] data_s;

        if (i == 0) begin : g_head
            assign up_valid_s = in_valid;
            assign up_data_s  = payload_s;
        end else begin : g_body
            assign up_valid_s = g_slice[i-1].valid_s;
            assign up_data_s  = g_slice[i-1].data_s;
        end

        if (i == NS - 1) begin : g_tail
            assign down_ready_s = out_ready;
        end else begin : g_mid
            assign down_ready_s = g_slice[i+1].adv_s;
        end

        lu_slice #(
            .W       (PW),
            .RST_VAL (PAYLOAD_RST)
        ) u_slice (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid   (up_valid_s),
            .up_data    (up_data_s),
            .down_ready (down_ready_s),
            .advance    (adv_s),
            .valid      (valid_s),
            .data       (data_s)
        );
    end

    assign in_ready  = g_slice[0].adv_s;
    assign out_valid = g_slice[NS-1].valid_s;
    assign f         = g_slice[NS-1].data_s[WIDTH-1:0];
`ifdef LU_FLAGS_EN
    assign zero      = g_slice[NS-1].data_s[WIDTH+1];
    assign ones      = g_slice[NS-1].data_s[WIDTH];
`endif

endmodule
